or1200_top_lite: RTL and testbench
==================================

Name:
or1200_top_lite

Overview:
- Reduced, multi-cycle OpenRISC 1000 (ORBIS32 subset) processor core.
- Big-endian, 32 general registers, branch delay slots.
- Fetches instructions over a Wishbone instruction master and performs loads/stores over a Wishbone data master.
- Sits where the full processor top sits, facing simple single-cycle-ack memory slaves.

Parameters:
- RESET_PC, 32'h0000_0100, address of the first instruction fetched after reset.

Ports:
- clk_i  in  1  sole clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- iwb_ack_i  in  1  instruction bus acknowledge.
- iwb_err_i  in  1  instruction bus error.
- iwb_rty_i  in  1  instruction bus retry.
- iwb_dat_i  in  32  fetched instruction word.
- iwb_cyc_o / iwb_stb_o  out  1 / 1  instruction cycle and strobe.
- iwb_adr_o  out  32  fetch address, word aligned.
- iwb_we_o  out  1  constant 0.
- iwb_sel_o  out  4  constant 4'hF.
- iwb_dat_o  out  32  constant 0.
- iwb_cti_o / iwb_bte_o  out  3 / 2  constant 0 (classic cycles).
- dwb_ack_i / dwb_err_i / dwb_rty_i  in  1 each  data bus acknowledge, error, retry.
- dwb_dat_i  in  32  load data.
- dwb_cyc_o / dwb_stb_o / dwb_we_o  out  1 each  data cycle, strobe, write enable.
- dwb_adr_o  out  32  effective address.
- dwb_sel_o  out  4  byte lanes.
- dwb_dat_o  out  32  store data.
- dwb_cti_o / dwb_bte_o  out  3 / 2  constant 0.
- dbg_stall_i  in  1  debug stall.
- pm_cpustall_i  in  1  power-management stall.
- pic_ints_i  in  20  interrupt inputs; accepted but ignored.
- halted_o  out  1  core halted on a bus error.

Behaviour:
- Reset (rst_i==0 at an edge):
  - All bus outputs 0, halted_o=0, SR.F=0.
  - PC=RESET_PC; registers r0..r31 cleared to 0.
  - Aborts any bus cycle in progress.
- State machine: FETCH -> EXEC -> (MEM for loads/stores) -> FETCH; HALT is terminal until reset.
- FETCH:
  - Drives cyc=stb=1 and adr=PC.
  - Holds them until ack. On ack, latches the instruction and deasserts cyc/stb on the same edge (no back-to-back strobe).
  - rty: drop cyc/stb for one cycle, then retry.
  - err: go to HALT.
- Stalls: if dbg_stall_i or pm_cpustall_i is high in FETCH or EXEC before a cycle starts, the core holds state and starts no new bus cycle. A cycle already in progress completes normally.
- EXEC: one cycle. Register writeback happens at the end of EXEC, or of MEM for loads. Writes to r0 are discarded; r0 always reads 0.
- Decode, opcode = insn[31:26]; rD=[25:21], rA=[20:16], rB=[15:11], imm16=[15:0]:
  - 0x00 l.j, 0x01 l.jal (r9 = PC+8), 0x03 l.bnf, 0x04 l.bf. Target = PC + (signext(insn[25:0])<<2).
  - 0x05 l.nop.
  - 0x06 l.movhi: rD = imm16<<16.
  - 0x11 l.jr: target = rB.
  - 0x21 l.lwz, 0x23 l.lbz (zero-extended byte).
  - 0x27 l.addi (sign-extended), 0x29 l.andi (zero-extended), 0x2A l.ori (zero-extended), 0x2B l.xori (sign-extended).
  - 0x2F l.sfXXi: compares rA with signext(imm16).
  - 0x35 l.sw, 0x36 l.sb: offset = signext({insn[25:21],insn[10:0]}); store data from rB.
  - 0x38 ALU, function in insn[3:0]: 0 add, 2 sub, 3 and, 4 or, 5 xor. Add/sub wrap modulo 2^32.
  - 0x39 l.sfXX: compares rA with rB.
  - Set-flag condition in insn[25:21]: 0 eq, 1 ne, 2 gtu, 3 geu, 4 ltu, 5 leu, A gts, B ges, C lts, D les.
  - Any other opcode, function or condition code executes as l.nop.
- Delay slot:
  - A taken jump or branch records its target. The following instruction (PC+4) always executes; then PC = target.
  - A jump placed in a delay slot is executed as l.nop.
  - Otherwise PC = PC+4.
- MEM:
  - Effective address = rA + offset.
  - lwz/sw: sel=4'hF.
  - Byte access, big-endian: addr[1:0]=0 -> sel 4'b1000 on lane [31:24]; 1 -> 4'b0100; 2 -> 4'b0010; 3 -> 4'b0001.
  - sb replicates the byte on all lanes.
  - Word accesses are not checked for alignment; addr[1:0] is driven as computed.
  - Bus handshake, rty and err handling are the same as FETCH.
- Latency with a next-cycle-ack slave: non-memory instruction = 3 cycles; load/store = 5 cycles.

Decomposition:
- Package or1200_lite_pkg: opcode, ALU-function and set-flag-condition constants; state enum; RESET_PC default.
- Sub-module or1200_lite_regfile: 32x32, two asynchronous read ports, one synchronous write port, r0 hardwired to 0.

Test Plan:
- Reset then release, all memory l.nop (0x15000000) -> fetch addresses 0x100, 0x104, 0x108 …, one fetch every 3 cycles, dwb_cyc_o stays 0.
- l.movhi r3,0x1234; l.ori r3,r3,0x5678; l.sw 0(r0),r3 -> DWRITE addr 0x0, data 0x12345678, sel F.
- l.addi r4,r0,-1; l.sb 3(r0),r4; l.lwz r5,0(r0); l.sw 4(r0),r5 -> sb uses sel 0x1; final store data 0x000000FF.
- l.sfeqi r0,0; l.bf +3; l.addi r6,r0,7 (delay slot); … -> delay-slot instruction executes, next fetch is branch_PC+12; l.sfnei r0,0 instead -> no branch.
- l.jal to a routine, then l.jr r9 -> r9 = jal_PC+8 and execution returns there after the l.jr delay slot.
- iwb_err_i pulsed during fetch -> halted_o=1 and no further bus cycles; rst_i low for one edge -> restart at 0x100.

Source files
------------

// File: rtl/or1200_lite_pkg.sv
// Shared decode constants, state encoding and small helpers for the reduced OR1200 core.
package or1200_lite_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0100;

    localparam logic [5:0] OP_J     = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h01;
    localparam logic [5:0] OP_BNF   = 6'h03;
    localparam logic [5:0] OP_BF    = 6'h04;
    localparam logic [5:0] OP_NOP   = 6'h05;
    localparam logic [5:0] OP_MOVHI = 6'h06;
    localparam logic [5:0] OP_JR    = 6'h11;
    localparam logic [5:0] OP_LWZ   = 6'h21;
    localparam logic [5:0] OP_LBZ   = 6'h23;
    localparam logic [5:0] OP_ADDI  = 6'h27;
    localparam logic [5:0] OP_ANDI  = 6'h29;
    localparam logic [5:0] OP_ORI   = 6'h2A;
    localparam logic [5:0] OP_XORI  = 6'h2B;
    localparam logic [5:0] OP_SFI   = 6'h2F;
    localparam logic [5:0] OP_SW    = 6'h35;
    localparam logic [5:0] OP_SB    = 6'h36;
    localparam logic [5:0] OP_ALU   = 6'h38;
    localparam logic [5:0] OP_SF    = 6'h39;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h2;
    localparam logic [3:0] FN_AND = 4'h3;
    localparam logic [3:0] FN_OR  = 4'h4;
    localparam logic [3:0] FN_XOR = 4'h5;

    localparam logic [4:0] SF_EQ  = 5'h00;
    localparam logic [4:0] SF_NE  = 5'h01;
    localparam logic [4:0] SF_GTU = 5'h02;
    localparam logic [4:0] SF_GEU = 5'h03;
    localparam logic [4:0] SF_LTU = 5'h04;
    localparam logic [4:0] SF_LEU = 5'h05;
    localparam logic [4:0] SF_GTS = 5'h0A;
    localparam logic [4:0] SF_GES = 5'h0B;
    localparam logic [4:0] SF_LTS = 5'h0C;
    localparam logic [4:0] SF_LES = 5'h0D;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    // Bit 1 says the condition code is recognised, bit 0 is the comparison result.
    function automatic logic [1:0] sf_eval(input logic [4:0] cond, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [1:0] r;
        r = 2'b10;
        case (cond)
            SF_EQ:   r[0] = (a == b);
            SF_NE:   r[0] = (a != b);
            SF_GTU:  r[0] = (a > b);
            SF_GEU:  r[0] = (a >= b);
            SF_LTU:  r[0] = (a < b);
            SF_LEU:  r[0] = (a <= b);
            SF_GTS:  r[0] = ($signed(a) > $signed(b));
            SF_GES:  r[0] = ($signed(a) >= $signed(b));
            SF_LTS:  r[0] = ($signed(a) < $signed(b));
            SF_LES:  r[0] = ($signed(a) <= $signed(b));
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_lane(input logic [1:0] a);
        logic [3:0] s;
        case (a)
            2'd0:    s = 4'b1000;
            2'd1:    s = 4'b0100;
            2'd2:    s = 4'b0010;
            default: s = 4'b0001;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] a);
        logic [7:0] b;
        case (a)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/or1200_lite_regfile.sv
// 32x32 general register file: two asynchronous read ports, one synchronous write port, r0 reads 0.
module or1200_lite_regfile
    import or1200_lite_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];

endmodule

// File: rtl/or1200_top_lite.sv
// Reduced multi-cycle OR1200 core: FETCH -> EXEC -> (MEM) -> FETCH over two classic Wishbone masters.
module or1200_top_lite
    import or1200_lite_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iwb_ack_i,
    input  logic        iwb_err_i,
    input  logic        iwb_rty_i,
    input  logic [31:0] iwb_dat_i,
    output logic        iwb_cyc_o,
    output logic        iwb_stb_o,
    output logic [31:0] iwb_adr_o,
    output logic        iwb_we_o,
    output logic [3:0]  iwb_sel_o,
    output logic [31:0] iwb_dat_o,
    output logic [2:0]  iwb_cti_o,
    output logic [1:0]  iwb_bte_o,
    input  logic        dwb_ack_i,
    input  logic        dwb_err_i,
    input  logic        dwb_rty_i,
    input  logic [31:0] dwb_dat_i,
    output logic        dwb_cyc_o,
    output logic        dwb_stb_o,
    output logic        dwb_we_o,
    output logic [31:0] dwb_adr_o,
    output logic [3:0]  dwb_sel_o,
    output logic [31:0] dwb_dat_o,
    output logic [2:0]  dwb_cti_o,
    output logic [1:0]  dwb_bte_o,
    input  logic        dbg_stall_i,
    input  logic        pm_cpustall_i,
    input  logic [19:0] pic_ints_i,
    output logic        halted_o
);

    state_t      state, state_n;
    logic [31:0] pc, pc_n, insn, insn_n, br_target, target_n;
    logic        dly_pending, dly_n, sr_f, sr_f_n;
    logic        iwb_cyc, iwb_cyc_n;
    logic [31:0] iwb_adr, iwb_adr_n;
    logic        dwb_cyc, dwb_cyc_n, dwb_we, dwb_we_n;
    logic [31:0] dwb_adr, dwb_adr_n, dwb_dat, dwb_dat_n;
    logic [3:0]  dwb_sel, dwb_sel_n;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, ra_val, rb_val;

    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] imm_sext, imm_zext, st_off, br_off, pc_seq, ld_ea, st_ea, sf_b;
    logic [1:0]  sf_res;
    logic        take, go_mem, stall, unused_ints;

    assign opcode   = insn[31:26];
    assign rd       = insn[25:21];
    assign imm_sext = {{16{insn[15]}}, insn[15:0]};
    assign imm_zext = {16'h0, insn[15:0]};
    assign st_off   = {{16{insn[25]}}, insn[25:21], insn[10:0]};
    assign br_off   = {{4{insn[25]}}, insn[25:0], 2'b00};
    assign pc_seq   = pc + 32'd4;
    assign ld_ea    = ra_val + imm_sext;
    assign st_ea    = ra_val + st_off;
    assign sf_b     = (opcode == OP_SF) ? rb_val : imm_sext;
    assign sf_res   = sf_eval(insn[25:21], ra_val, sf_b);
    assign take     = (opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_JR) ||
                      ((opcode == OP_BF) && sr_f) || ((opcode == OP_BNF) && !sr_f);
    assign stall    = dbg_stall_i | pm_cpustall_i;
    assign unused_ints = ^pic_ints_i;

    or1200_lite_regfile u_regfile (
        .clk     (clk_i),
        .rst     (rst_i),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (insn[20:16]),
        .raddr_b (insn[15:11]),
        .rdata_a (ra_val),
        .rdata_b (rb_val)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            insn        <= '0;
            br_target   <= '0;
            dly_pending <= 1'b0;
            sr_f        <= 1'b0;
            iwb_cyc     <= 1'b0;
            iwb_adr     <= '0;
            dwb_cyc     <= 1'b0;
            dwb_we      <= 1'b0;
            dwb_adr     <= '0;
            dwb_sel     <= '0;
            dwb_dat     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            insn        <= insn_n;
            br_target   <= target_n;
            dly_pending <= dly_n;
            sr_f        <= sr_f_n;
            iwb_cyc     <= iwb_cyc_n;
            iwb_adr     <= iwb_adr_n;
            dwb_cyc     <= dwb_cyc_n;
            dwb_we      <= dwb_we_n;
            dwb_adr     <= dwb_adr_n;
            dwb_sel     <= dwb_sel_n;
            dwb_dat     <= dwb_dat_n;
        end
    end

    // Completing EXEC or MEM launches the next fetch on the same edge, which keeps a
    // plain instruction at 3 cycles and a load/store at 5 with a next-cycle-ack slave.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        insn_n    = insn;
        target_n  = br_target;
        dly_n     = dly_pending;
        sr_f_n    = sr_f;
        iwb_cyc_n = iwb_cyc;
        iwb_adr_n = iwb_adr;
        dwb_cyc_n = dwb_cyc;
        dwb_we_n  = dwb_we;
        dwb_adr_n = dwb_adr;
        dwb_sel_n = dwb_sel;
        dwb_dat_n = dwb_dat;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = '0;
        go_mem    = 1'b0;
        case (state)
            ST_FETCH: begin
                if (iwb_cyc) begin
                    if (iwb_err_i) begin
                        iwb_cyc_n = 1'b0;
                        state_n   = ST_HALT;
                    end else if (iwb_ack_i) begin
                        insn_n    = iwb_dat_i;
                        iwb_cyc_n = 1'b0;
                        state_n   = ST_EXEC;
                    end else if (iwb_rty_i) begin
                        iwb_cyc_n = 1'b0;
                    end
                end else if (!stall) begin
                    iwb_cyc_n = 1'b1;
                    iwb_adr_n = pc;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_n  = dly_pending ? br_target : pc_seq;
                    dly_n = 1'b0;
                    case (opcode)
                        OP_J, OP_JAL, OP_BNF, OP_BF, OP_JR: begin
                            // Control transfers sitting in a delay slot are ignored.
                            if (!dly_pending) begin
                                if (take) begin
                                    dly_n    = 1'b1;
                                    target_n = (opcode == OP_JR) ? rb_val : pc + br_off;
                                end
                                if (opcode == OP_JAL) begin
                                    rf_we    = 1'b1;
                                    rf_waddr = 5'd9;
                                    rf_wdata = pc + 32'd8;
                                end
                            end
                        end
                        OP_NOP: ;
                        OP_MOVHI: begin
                            rf_we    = 1'b1;
                            rf_wdata = {insn[15:0], 16'h0};
                        end
                        OP_LWZ, OP_LBZ: begin
                            go_mem    = 1'b1;
                            dwb_we_n  = 1'b0;
                            dwb_adr_n = ld_ea;
                            dwb_sel_n = (opcode == OP_LWZ) ? 4'hF : byte_lane(ld_ea[1:0]);
                            dwb_dat_n = '0;
                        end
                        OP_SW, OP_SB: begin
                            go_mem    = 1'b1;
                            dwb_we_n  = 1'b1;
                            dwb_adr_n = st_ea;
                            dwb_sel_n = (opcode == OP_SW) ? 4'hF : byte_lane(st_ea[1:0]);
                            dwb_dat_n = (opcode == OP_SW) ? rb_val : {4{rb_val[7:0]}};
                        end
                        OP_ADDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = ra_val + imm_sext;
                        end
                        OP_ANDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = ra_val & imm_zext;
                        end
                        OP_ORI: begin
                            rf_we    = 1'b1;
                            rf_wdata = ra_val | imm_zext;
                        end
                        OP_XORI: begin
                            rf_we    = 1'b1;
                            rf_wdata = ra_val ^ imm_sext;
                        end
                        OP_SFI, OP_SF: begin
                            if (sf_res[1]) sr_f_n = sf_res[0];
                        end
                        OP_ALU: begin
                            rf_we = 1'b1;
                            case (insn[3:0])
                                FN_ADD:  rf_wdata = ra_val + rb_val;
                                FN_SUB:  rf_wdata = ra_val - rb_val;
                                FN_AND:  rf_wdata = ra_val & rb_val;
                                FN_OR:   rf_wdata = ra_val | rb_val;
                                FN_XOR:  rf_wdata = ra_val ^ rb_val;
                                default: rf_we = 1'b0;
                            endcase
                        end
                        default: ;
                    endcase
                    if (go_mem) begin
                        dwb_cyc_n = 1'b1;
                        state_n   = ST_MEM;
                    end else begin
                        iwb_cyc_n = 1'b1;
                        iwb_adr_n = pc_n;
                        state_n   = ST_FETCH;
                    end
                end
            end
            ST_MEM: begin
                if (dwb_cyc) begin
                    if (dwb_err_i || dwb_ack_i) begin
                        dwb_cyc_n = 1'b0;
                        dwb_we_n  = 1'b0;
                        dwb_adr_n = '0;
                        dwb_sel_n = '0;
                        dwb_dat_n = '0;
                    end
                    if (dwb_err_i) begin
                        state_n = ST_HALT;
                    end else if (dwb_ack_i) begin
                        if (!dwb_we) begin
                            rf_we    = 1'b1;
                            rf_wdata = (opcode == OP_LBZ) ?
                                       {24'h0, pick_byte(dwb_dat_i, dwb_adr[1:0])} : dwb_dat_i;
                        end
                        state_n = ST_FETCH;
                        if (!stall) begin
                            iwb_cyc_n = 1'b1;
                            iwb_adr_n = pc;
                        end
                    end else if (dwb_rty_i) begin
                        dwb_cyc_n = 1'b0;
                    end
                end else begin
                    dwb_cyc_n = 1'b1;
                end
            end
            ST_HALT: ;
            default: state_n = ST_HALT;
        endcase
    end

    assign iwb_cyc_o = iwb_cyc;
    assign iwb_stb_o = iwb_cyc;
    assign iwb_adr_o = iwb_adr;
    assign iwb_we_o  = 1'b0;
    assign iwb_sel_o = 4'hF;
    assign iwb_dat_o = 32'h0;
    assign iwb_cti_o = 3'd0;
    assign iwb_bte_o = 2'd0;

    assign dwb_cyc_o = dwb_cyc;
    assign dwb_stb_o = dwb_cyc;
    assign dwb_we_o  = dwb_we;
    assign dwb_adr_o = dwb_adr;
    assign dwb_sel_o = dwb_sel;
    assign dwb_dat_o = dwb_dat;
    assign dwb_cti_o = 3'd0;
    assign dwb_bte_o = 2'd0;

    assign halted_o = (state == ST_HALT);

endmodule

// File: tb/tb_or1200_top_lite.sv
// Directed bench for or1200_top_lite with next-cycle-ack instruction and data memory models.
module tb_or1200_top_lite;

    localparam logic [31:0] NOP = 32'h1500_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iwb_ack, iwb_err, iwb_rty, iwb_cyc, iwb_stb, iwb_we;
    logic [31:0] iwb_dat_in, iwb_adr, iwb_dat_out;
    logic [3:0]  iwb_sel;
    logic [2:0]  iwb_cti;
    logic [1:0]  iwb_bte;
    logic        dwb_ack, dwb_err, dwb_rty, dwb_cyc, dwb_stb, dwb_we;
    logic [31:0] dwb_dat_in, dwb_adr, dwb_dat_out;
    logic [3:0]  dwb_sel;
    logic [2:0]  dwb_cti;
    logic [1:0]  dwb_bte;
    logic        dbg_stall = 1'b0;
    logic        pm_cpustall = 1'b0;
    logic [19:0] pic_ints = '0;
    logic        halted;
    logic        err_mode = 1'b0;

    logic [31:0] imem [256];
    logic [31:0] dmem [64];

    logic [31:0] fetch_q[$];
    int          fetch_cyc_q[$];
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    logic [31:0] wr_sel_q[$];
    int          cycle = 0;
    int          istb_count = 0;
    logic        dwb_seen = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    assign iwb_rty    = 1'b0;
    assign dwb_err    = 1'b0;
    assign dwb_rty    = 1'b0;
    assign iwb_dat_in = imem[iwb_adr[9:2]];
    assign dwb_dat_in = dmem[dwb_adr[7:2]];

    or1200_top_lite dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .iwb_ack_i     (iwb_ack),
        .iwb_err_i     (iwb_err),
        .iwb_rty_i     (iwb_rty),
        .iwb_dat_i     (iwb_dat_in),
        .iwb_cyc_o     (iwb_cyc),
        .iwb_stb_o     (iwb_stb),
        .iwb_adr_o     (iwb_adr),
        .iwb_we_o      (iwb_we),
        .iwb_sel_o     (iwb_sel),
        .iwb_dat_o     (iwb_dat_out),
        .iwb_cti_o     (iwb_cti),
        .iwb_bte_o     (iwb_bte),
        .dwb_ack_i     (dwb_ack),
        .dwb_err_i     (dwb_err),
        .dwb_rty_i     (dwb_rty),
        .dwb_dat_i     (dwb_dat_in),
        .dwb_cyc_o     (dwb_cyc),
        .dwb_stb_o     (dwb_stb),
        .dwb_we_o      (dwb_we),
        .dwb_adr_o     (dwb_adr),
        .dwb_sel_o     (dwb_sel),
        .dwb_dat_o     (dwb_dat_out),
        .dwb_cti_o     (dwb_cti),
        .dwb_bte_o     (dwb_bte),
        .dbg_stall_i   (dbg_stall),
        .pm_cpustall_i (pm_cpustall),
        .pic_ints_i    (pic_ints),
        .halted_o      (halted)
    );

    // Slaves answer one cycle after a strobe; data memory is cleared while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            iwb_ack <= 1'b0;
            iwb_err <= 1'b0;
            dwb_ack <= 1'b0;
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else begin
            iwb_ack <= iwb_cyc && iwb_stb && !iwb_ack && !iwb_err && !err_mode;
            iwb_err <= iwb_cyc && iwb_stb && !iwb_ack && !iwb_err && err_mode;
            dwb_ack <= dwb_cyc && dwb_stb && !dwb_ack;
            if (dwb_cyc && dwb_stb && dwb_we && dwb_ack) begin
                for (int b = 0; b < 4; b++)
                    if (dwb_sel[b]) dmem[dwb_adr[7:2]][b*8 +: 8] <= dwb_dat_out[b*8 +: 8];
            end
        end
    end

    always @(posedge clk) begin
        cycle = cycle + 1;
        if (iwb_cyc) istb_count = istb_count + 1;
        if (!rst) begin
            fetch_q.delete();
            fetch_cyc_q.delete();
            wr_adr_q.delete();
            wr_dat_q.delete();
            wr_sel_q.delete();
            dwb_seen = 1'b0;
        end else begin
            if (dwb_cyc) dwb_seen = 1'b1;
            if (iwb_cyc && iwb_stb && iwb_ack) begin
                fetch_q.push_back(iwb_adr);
                fetch_cyc_q.push_back(cycle);
            end
            if (dwb_cyc && dwb_stb && dwb_we && dwb_ack) begin
                wr_adr_q.push_back(dwb_adr);
                wr_dat_q.push_back(dwb_dat_out);
                wr_sel_q.push_back({28'h0, dwb_sel});
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] fetchAt(input int i);
        return (i < fetch_q.size()) ? fetch_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] fetchGap(input int i);
        return (i + 1 < fetch_cyc_q.size()) ? 32'(fetch_cyc_q[i+1] - fetch_cyc_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wrAdr(input int i);
        return (i < wr_adr_q.size()) ? wr_adr_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wrDat(input int i);
        return (i < wr_dat_q.size()) ? wr_dat_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wrSel(input int i);
        return (i < wr_sel_q.size()) ? wr_sel_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic loadNops();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
    endtask

    task automatic putInsn(input logic [31:0] adr, input logic [31:0] word);
        imem[adr[9:2]] = word;
    endtask

    // Reset for two edges, release, then let the program run for a fixed number of cycles.
    task automatic applyStimulus(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        err_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int n0, n1, snap;
        loadNops();

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("rst_iwb_cyc", {31'h0, iwb_cyc}, 32'h0);
        checkOutput("rst_dwb_cyc", {31'h0, dwb_cyc}, 32'h0);
        checkOutput("rst_halted", {31'h0, halted}, 32'h0);
        checkOutput("rst_iwb_adr", iwb_adr, 32'h0);
        checkOutput("rst_dwb_sel", {28'h0, dwb_sel}, 32'h0);

        $display("[TB] nop stream and stall");
        applyStimulus(20);
        checkOutput("nop_fetch0", fetchAt(0), 32'h100);
        checkOutput("nop_fetch1", fetchAt(1), 32'h104);
        checkOutput("nop_fetch2", fetchAt(2), 32'h108);
        checkOutput("nop_gap0", fetchGap(0), 32'd3);
        checkOutput("nop_gap1", fetchGap(1), 32'd3);
        checkOutput("nop_no_dwb", {31'h0, dwb_seen}, 32'h0);
        n0 = fetch_q.size();
        pm_cpustall = 1'b1;
        repeat (12) @(negedge clk);
        n1 = fetch_q.size();
        checkOutput("stall_hold", {31'h0, (n1 - n0) <= 1}, 32'h1);
        checkOutput("stall_no_cyc", {31'h0, iwb_cyc}, 32'h0);
        pm_cpustall = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("stall_resume", {31'h0, fetch_q.size() >= n1 + 2}, 32'h1);

        $display("[TB] movhi/ori/sw");
        loadNops();
        putInsn(32'h100, 32'h1860_1234);
        putInsn(32'h104, 32'hA863_5678);
        putInsn(32'h108, 32'hD400_1800);
        applyStimulus(30);
        checkOutput("sw_count", 32'(wr_adr_q.size()), 32'd1);
        checkOutput("sw_adr", wrAdr(0), 32'h0);
        checkOutput("sw_dat", wrDat(0), 32'h1234_5678);
        checkOutput("sw_sel", wrSel(0), 32'hF);
        checkOutput("sw_latency", fetchGap(2), 32'd5);

        $display("[TB] addi/sb/lwz/sw");
        loadNops();
        putInsn(32'h100, 32'h9C80_FFFF);
        putInsn(32'h104, 32'hD800_2003);
        putInsn(32'h108, 32'h84A0_0000);
        putInsn(32'h10C, 32'hD400_2804);
        applyStimulus(40);
        checkOutput("sb_adr", wrAdr(0), 32'h3);
        checkOutput("sb_sel", wrSel(0), 32'h1);
        checkOutput("sb_dat", wrDat(0), 32'hFFFF_FFFF);
        checkOutput("ld_sw_adr", wrAdr(1), 32'h4);
        checkOutput("ld_sw_dat", wrDat(1), 32'h0000_00FF);
        checkOutput("ld_sw_sel", wrSel(1), 32'hF);

        $display("[TB] taken branch with delay slot");
        loadNops();
        putInsn(32'h100, 32'hBC00_0000);
        putInsn(32'h104, 32'h1000_0003);
        putInsn(32'h108, 32'h9CC0_0007);
        putInsn(32'h10C, 32'h9CC0_0055);
        putInsn(32'h110, 32'hD400_3000);
        applyStimulus(30);
        checkOutput("bf_fetch2", fetchAt(2), 32'h108);
        checkOutput("bf_fetch3", fetchAt(3), 32'h110);
        checkOutput("bf_dat", wrDat(0), 32'h7);

        $display("[TB] branch not taken");
        putInsn(32'h100, 32'hBC20_0000);
        applyStimulus(30);
        checkOutput("nbf_fetch3", fetchAt(3), 32'h10C);
        checkOutput("nbf_fetch4", fetchAt(4), 32'h110);
        checkOutput("nbf_dat", wrDat(0), 32'h55);

        $display("[TB] jal/jr");
        loadNops();
        putInsn(32'h100, 32'h0400_0004);
        putInsn(32'h104, 32'h9CE0_0001);
        putInsn(32'h108, 32'hD400_3804);
        putInsn(32'h110, 32'hD400_4800);
        putInsn(32'h114, 32'h4400_4800);
        putInsn(32'h118, 32'h9CE7_0002);
        applyStimulus(40);
        checkOutput("jal_fetch2", fetchAt(2), 32'h110);
        checkOutput("jr_fetch4", fetchAt(4), 32'h118);
        checkOutput("jr_fetch5", fetchAt(5), 32'h108);
        checkOutput("jal_r9", wrDat(0), 32'h108);
        checkOutput("jr_ret_adr", wrAdr(1), 32'h4);
        checkOutput("jr_ret_dat", wrDat(1), 32'h3);

        $display("[TB] fetch error halts");
        loadNops();
        applyStimulus(10);
        err_mode = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("err_halted", {31'h0, halted}, 32'h1);
        checkOutput("err_no_cyc", {31'h0, iwb_cyc}, 32'h0);
        snap = istb_count;
        repeat (20) @(negedge clk);
        checkOutput("err_quiet", 32'(istb_count - snap), 32'd0);
        checkOutput("err_no_dwb", {31'h0, dwb_cyc}, 32'h0);
        rst = 1'b0;
        err_mode = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rst1_halted", {31'h0, halted}, 32'h0);
        repeat (8) @(negedge clk);
        checkOutput("rst1_fetch0", fetchAt(0), 32'h100);
        checkOutput("rst1_fetch1", fetchAt(1), 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
